// File: rtl/hazard_pkg.sv
// Shared constants for the load-use hazard scoreboard: default widths and latencies.
package hazard_pkg;

  localparam int REG_AW_DEF   = 3;
  localparam int CNT_W        = 3;
  localparam int LOAD_LAT_DEF = 1;
  localparam int ALU_LAT_DEF  = 0;

  // Stall cycles owed to readers of a freshly issued writer.
  function automatic logic [CNT_W-1:0] owed_cycles(input logic is_load,
                                                  input int   load_lat,
                                                  input int   alu_lat);
    return is_load ? CNT_W'(load_lat) : CNT_W'(alu_lat);
  endfunction

endpackage

// File: rtl/hazard_sb_entry.sv
// One scoreboard slot: remaining stall cycles owed by a single architectural register.
module hazard_sb_entry
  import hazard_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             busy
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // A new writer overrides any count still running down.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign busy = (cnt_q != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// Per-register stall scoreboard driving ID-stage bubble / PC / IF-ID enables.
// Define HAZARD_STATS_EN to add the saturating stall_count statistic output.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int REG_AW   = REG_AW_DEF,
  parameter int LOAD_LAT = LOAD_LAT_DEF,
  parameter int ALU_LAT  = ALU_LAT_DEF,
  parameter int R0_ZERO  = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_rs_used,
  input  logic              id_rt_used,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_wr_en,
  input  logic              id_is_load,
  input  logic              flush,
  output logic              hazard,
  output logic              PCwrite,
  output logic              IF_IDwrite
`ifdef HAZARD_STATS_EN
  ,
  output logic [15:0]       stall_count
`endif
);

  localparam int NREG = 1 << REG_AW;

  logic [NREG-1:0]  busy;
  logic [NREG-1:0]  load_vec;
  logic [CNT_W-1:0] load_val;
  logic             rs_busy, rt_busy, raw, issue;

  // Register 0 is hardwired when R0_ZERO is set, so it can never be owed a stall.
  assign rs_busy = id_rs_used && busy[id_rs] && !((R0_ZERO != 0) && (id_rs == '0));
  assign rt_busy = id_rt_used && busy[id_rt] && !((R0_ZERO != 0) && (id_rt == '0));
  assign raw     = id_valid && (rs_busy || rt_busy);

  assign hazard     = raw && !flush;
  assign PCwrite    = !hazard;
  assign IF_IDwrite = !hazard;
  assign issue      = id_valid && !hazard && !flush;
  assign load_val   = owed_cycles(id_is_load, LOAD_LAT, ALU_LAT);

  for (genvar g = 0; g < NREG; g++) begin : g_entry
    localparam bit R0_MASK = (R0_ZERO != 0) && (g == 0);

    assign load_vec[g] = issue && id_wr_en && (id_rd == REG_AW'(g)) && !R0_MASK;

    hazard_sb_entry u_entry (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (load_vec[g]),
      .load_val (load_val),
      .busy     (busy[g])
    );
  end

`ifdef HAZARD_STATS_EN
  logic [15:0] stall_count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_count_q <= '0;
    end else if (hazard && (stall_count_q != 16'hFFFF)) begin
      stall_count_q <= stall_count_q + 16'd1;
    end
  end

  assign stall_count = stall_count_q;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard over four parameter sets.
module tb_hazard_scoreboard;
  import hazard_pkg::*;

  localparam int NI = 4;
  // 0: defaults, 1: LOAD_LAT=3/ALU_LAT=1, 2: zero latencies, 3: R0_ZERO=0
  localparam int LLT [NI] = '{1, 3, 0, 1};
  localparam int ALT [NI] = '{0, 1, 0, 0};
  localparam int R0T [NI] = '{1, 1, 1, 0};

  logic       clk = 1'b0;
  logic       rst_n;
  logic       vld [NI];
  logic [2:0] rs  [NI];
  logic [2:0] rt  [NI];
  logic       rsu [NI];
  logic       rtu [NI];
  logic [2:0] rd  [NI];
  logic       wr  [NI];
  logic       ld  [NI];
  logic       fl  [NI];
  logic       hz  [NI];
  logic       pcw [NI];
  logic       ifw [NI];
`ifdef HAZARD_STATS_EN
  logic [15:0] sc [NI];
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  for (genvar i = 0; i < NI; i++) begin : g_dut
    hazard_scoreboard #(
      .REG_AW   (3),
      .LOAD_LAT (LLT[i]),
      .ALU_LAT  (ALT[i]),
      .R0_ZERO  (R0T[i])
    ) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .id_valid   (vld[i]),
      .id_rs      (rs[i]),
      .id_rt      (rt[i]),
      .id_rs_used (rsu[i]),
      .id_rt_used (rtu[i]),
      .id_rd      (rd[i]),
      .id_wr_en   (wr[i]),
      .id_is_load (ld[i]),
      .flush      (fl[i]),
      .hazard     (hz[i]),
      .PCwrite    (pcw[i]),
      .IF_IDwrite (ifw[i])
`ifdef HAZARD_STATS_EN
      ,
      .stall_count(sc[i])
`endif
    );
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_hz(input string tag, input int k, input logic exp);
    chk(tag, 32'(hz[k]), 32'(exp));
    chk({tag, "_pc"}, 32'(pcw[k]), 32'(!exp));
    chk({tag, "_ifid"}, 32'(ifw[k]), 32'(!exp));
  endtask

  task automatic idle_all();
    for (int j = 0; j < NI; j++) begin
      vld[j] = 0; rs[j] = 0; rt[j] = 0; rsu[j] = 0; rtu[j] = 0;
      rd[j] = 0;  wr[j] = 0; ld[j] = 0; fl[j] = 0;
    end
  endtask

  // Present one ID instruction to instance k (others idle) and let it settle.
  task automatic cyc(input int k, input logic f, input logic [2:0] a, input logic au,
                     input logic [2:0] b, input logic bu, input logic [2:0] d,
                     input logic w, input logic l);
    @(negedge clk);
    idle_all();
    vld[k] = 1; fl[k] = f; rs[k] = a; rsu[k] = au; rt[k] = b; rtu[k] = bu;
    rd[k] = d; wr[k] = w; ld[k] = l;
    #1;
  endtask

  initial begin
    idle_all();
    rst_n = 0;
    #1;
    for (int k = 0; k < NI; k++) chk_hz($sformatf("reset_hz%0d", k), k, 1'b0);
`ifdef HAZARD_STATS_EN
    chk("reset_sc", 32'(sc[0]), 32'd0);
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1;

    // No sources used: never stalls, even after writers.
    cyc(0, 0, 3'd1, 0, 3'd2, 0, 3'd1, 1, 1); chk_hz("nouse_a", 0, 0);
    cyc(0, 0, 3'd1, 0, 3'd1, 0, 3'd0, 0, 0); chk_hz("nouse_b", 0, 0);
    cyc(0, 0, 3'd0, 0, 3'd0, 0, 3'd0, 0, 0); chk_hz("nouse_c", 0, 0);

    // Load r4, then consumer rt=4 stalls exactly one cycle.
    cyc(0, 0, 3'd0, 0, 3'd0, 0, 3'd4, 1, 1); chk_hz("ld4_issue", 0, 0);
    cyc(0, 0, 3'd0, 0, 3'd4, 1, 3'd5, 1, 0); chk_hz("use4_stall", 0, 1);
    cyc(0, 0, 3'd0, 0, 3'd4, 1, 3'd5, 1, 0); chk_hz("use4_go", 0, 0);
    cyc(0, 0, 3'd5, 1, 3'd0, 0, 3'd0, 0, 0); chk_hz("alu0_nostall", 0, 0);

    // Load to r0 is ignored with R0_ZERO=1.
    cyc(0, 0, 3'd0, 0, 3'd0, 0, 3'd0, 1, 1); chk_hz("ld0_issue", 0, 0);
    cyc(0, 0, 3'd0, 1, 3'd0, 0, 3'd0, 0, 0); chk_hz("use0_r0zero", 0, 0);

    // Flushed consumer: no hazard, counter still drains, its own write dropped.
    cyc(0, 0, 3'd0, 0, 3'd0, 0, 3'd1, 1, 1); chk_hz("ld1_issue", 0, 0);
    cyc(0, 1, 3'd1, 1, 3'd0, 0, 3'd1, 1, 1); chk_hz("flush_hz", 0, 0);
    cyc(0, 0, 3'd1, 1, 3'd0, 0, 3'd0, 0, 0); chk_hz("after_flush", 0, 0);

    // rs==rt stalls once.
    cyc(0, 0, 3'd0, 0, 3'd0, 0, 3'd3, 1, 1); chk_hz("ld3_issue", 0, 0);
    cyc(0, 0, 3'd3, 1, 3'd3, 1, 3'd0, 0, 0); chk_hz("rsrt_stall", 0, 1);
    cyc(0, 0, 3'd3, 1, 3'd3, 1, 3'd0, 0, 0); chk_hz("rsrt_go", 0, 0);

    // Stalled load into its own source reloads only when it issues.
    cyc(0, 0, 3'd0, 0, 3'd0, 0, 3'd6, 1, 1); chk_hz("ld6_issue", 0, 0);
    cyc(0, 0, 3'd6, 1, 3'd0, 0, 3'd6, 1, 1); chk_hz("self_stall", 0, 1);
    cyc(0, 0, 3'd6, 1, 3'd0, 0, 3'd6, 1, 1); chk_hz("self_go", 0, 0);
    cyc(0, 0, 3'd6, 1, 3'd0, 0, 3'd0, 0, 0); chk_hz("self_reuse", 0, 1);
    cyc(0, 0, 3'd6, 1, 3'd0, 0, 3'd0, 0, 0); chk_hz("self_reuse_go", 0, 0);

    // LOAD_LAT=3: three stall cycles, then ALU_LAT=1 gives one.
    cyc(1, 0, 3'd0, 0, 3'd0, 0, 3'd2, 1, 1); chk_hz("b_ld2_issue", 1, 0);
    cyc(1, 0, 3'd2, 1, 3'd0, 0, 3'd0, 0, 0); chk_hz("b_stall1", 1, 1);
    cyc(1, 0, 3'd2, 1, 3'd0, 0, 3'd0, 0, 0); chk_hz("b_stall2", 1, 1);
    cyc(1, 0, 3'd2, 1, 3'd0, 0, 3'd0, 0, 0); chk_hz("b_stall3", 1, 1);
    cyc(1, 0, 3'd2, 1, 3'd0, 0, 3'd0, 0, 0); chk_hz("b_go", 1, 0);
`ifdef HAZARD_STATS_EN
    chk("b_stall_count", 32'(sc[1]), 32'd3);
`endif
    cyc(1, 0, 3'd0, 0, 3'd0, 0, 3'd5, 1, 0); chk_hz("b_alu5_issue", 1, 0);
    cyc(1, 0, 3'd5, 1, 3'd0, 0, 3'd0, 0, 0); chk_hz("b_alu_stall", 1, 1);
    cyc(1, 0, 3'd5, 1, 3'd0, 0, 3'd0, 0, 0); chk_hz("b_alu_go", 1, 0);

    // Zero latencies never stall.
    cyc(2, 0, 3'd0, 0, 3'd0, 0, 3'd3, 1, 1); chk_hz("z_ld3", 2, 0);
    cyc(2, 0, 3'd3, 1, 3'd0, 0, 3'd4, 1, 0); chk_hz("z_use3", 2, 0);
    cyc(2, 0, 3'd0, 0, 3'd4, 1, 3'd0, 0, 0); chk_hz("z_use4", 2, 0);

    // R0_ZERO=0: r0 is tracked like any other register.
    cyc(3, 0, 3'd0, 0, 3'd0, 0, 3'd0, 1, 1); chk_hz("c_ld0", 3, 0);
    cyc(3, 0, 3'd0, 1, 3'd0, 0, 3'd0, 0, 0); chk_hz("c_use0_stall", 3, 1);
    cyc(3, 0, 3'd0, 1, 3'd0, 0, 3'd0, 0, 0); chk_hz("c_use0_go", 3, 0);

    // Async reset in the middle of a stall.
    cyc(0, 0, 3'd0, 0, 3'd0, 0, 3'd1, 1, 1); chk_hz("rst_ld1", 0, 0);
    cyc(0, 0, 3'd1, 1, 3'd0, 0, 3'd0, 0, 0); chk_hz("rst_pre_stall", 0, 1);
    #2;
    rst_n = 0;
    #1;
    chk_hz("rst_async_hz", 0, 0);
`ifdef HAZARD_STATS_EN
    chk("rst_async_sc", 32'(sc[0]), 32'd0);
`endif
    @(negedge clk);
    rst_n = 1;
    cyc(0, 0, 3'd1, 1, 3'd0, 0, 3'd0, 0, 0); chk_hz("post_rst_use1", 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 Parameter REG_AW, default 3, register-address width; register file holds 2**REG_AW entries.
REQ-002 Parameter LOAD_LAT, default 1, stall cycles owed by a consumer issued directly after a load (range 0..7).
REQ-003 Parameter ALU_LAT, default 0, stall cycles owed after a non-load writer (range 0..7).
REQ-004 Parameter R0_ZERO, default 1; when 1, register 0 is never tracked.
REQ-005 clk  input  1  single clock; all state changes on rising edge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 id_valid  input  1  instruction present in ID.
REQ-008 id_rs, id_rt  input  REG_AW each  source register addresses.
REQ-009 id_rs_used, id_rt_used  input  1 each  source actually read.
REQ-010 id_rd  input  REG_AW  destination register.
REQ-011 id_wr_en  input  1  instruction writes id_rd.
REQ-012 id_is_load  input  1  instruction is a memory read.
REQ-013 flush  input  1  squash the ID instruction this cycle (taken branch/jump).
REQ-014 hazard  output  1  insert bubble into ID/EX.
REQ-015 PCwrite  output  1  PC update enable.
REQ-016 IF_IDwrite  output  1  IF/ID register write enable.
REQ-017 stall_count  output  16  stall-cycle statistic (present only with HAZARD_STATS_EN).

Function
REQ-018 Per register r, a counter cnt[r] (3 bits) SHALL hold the remaining stall cycles owed to any reader of r.
REQ-019 raw = id_valid & ((id_rs_used & cnt[id_rs]!=0) | (id_rt_used & cnt[id_rt]!=0)), combinational, zero latency.
REQ-020 hazard = raw & ~flush; PCwrite = ~hazard; IF_IDwrite = ~hazard.
REQ-021 Issue = id_valid & ~hazard & ~flush; on issue with id_wr_en, cnt[id_rd] loads LOAD_LAT if id_is_load else ALU_LAT.
REQ-022 Every other nonzero counter decrements by 1 each cycle; counters at 0 hold; no wrap below 0.
REQ-023 Issue-load and decrement on the same register in one cycle: load wins.
REQ-024 R0_ZERO=1: writes to register 0 never load cnt[0]; reads of register 0 never stall.
REQ-025 A consumer reading the same register twice (rs==rt) stalls once, not twice, per owed cycle.
REQ-026 Flush suppresses issue and forces hazard=0; counters of already-issued writers keep decrementing.
REQ-027 While stalled, the ID instruction never loads its own destination counter.
REQ-028 LOAD_LAT=0 and ALU_LAT=0 SHALL produce hazard constantly 0.

Reset
REQ-029 rst_n low SHALL clear all cnt[] immediately, independent of clk.
REQ-030 During and after reset until first issue: hazard=0, PCwrite=1, IF_IDwrite=1, stall_count=0.
REQ-031 Reset asserted mid-stall SHALL end the stall in the same cycle.

Configuration
REQ-032 Macro HAZARD_STATS_EN defined: stall_count increments on every clock edge with hazard=1, saturating at 16'hFFFF, cleared by reset.
REQ-033 Macro HAZARD_STATS_EN undefined: no stall_count port and no counter logic; all other behaviour identical.

Structure
REQ-034 Package hazard_pkg SHALL hold REG_AW default, counter width constant (3), LOAD_LAT/ALU_LAT defaults.
REQ-035 One sub-module hazard_sb_entry SHALL implement a single register counter (load, decrement, busy flag), instantiated 2**REG_AW times.

Verification
REQ-036 Reset then id_valid=1, all sources unused -> hazard=0, PCwrite=1, IF_IDwrite=1 every cycle.
REQ-037 Load to r4 issued, next cycle consumer rt=4 used, LOAD_LAT=1 -> hazard=1 for exactly 1 cycle, then issue.
REQ-038 LOAD_LAT=3, load to r2, consumer rs=2 next cycle -> hazard=1 for 3 consecutive cycles; with stats, stall_count=3.
REQ-039 Load to r0 with R0_ZERO=1, then consumer rs=0 -> hazard=0; same with R0_ZERO=0 -> hazard=1 one cycle.
REQ-040 Stalled consumer of r1 with flush=1 -> hazard=0 that cycle, cnt[r1] still decrements to 0, no issue recorded.
REQ-041 rst_n dropped while hazard=1 -> hazard=0 asynchronously, stall_count=0, first post-reset consumer of r1 does not stall.
